// File: rtl/csi2_frame_arbiter.sv
// Frame-level arbiter for the two-channel CSI-2 packet muxer: locks mux_sel to one
// channel from FS to FE and changes it only in inter-frame gaps.
module csi2_frame_arbiter #(
  parameter int TO_W        = 20,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int GUARD_CYC   = 8
) (
  input  logic       rx_byte_clk_fr,
  input  logic       reset_n,
  input  logic       arb_en,
  input  logic       fixed_sel,
  input  logic       lp_en_chA,
  input  logic       lp_en_chB,
  input  logic       sp_en_chA,
  input  logic       sp_en_chB,
  input  logic       d2c_payload_en_chA,
  input  logic       d2c_payload_en_chB,
  input  logic [5:0] dt_chA,
  input  logic [5:0] dt_chB,
  output logic       mux_sel,
  output logic       frame_active,
  output logic       timeout_pulse,
  output logic [7:0] drop_cnt_chA,
  output logic [7:0] drop_cnt_chB
);

  typedef enum logic [1:0] {
    WAIT_FS  = 2'd0,
    IN_FRAME = 2'd1,
    SWITCH   = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      GUARD_LAST = 8'(GUARD_CYC - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      guard_cnt_q, guard_cnt_d;
  logic            mux_sel_q, mux_sel_d;
  logic            frame_active_q, frame_active_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      drop_a_q, drop_a_d;
  logic [7:0]      drop_b_q, drop_b_d;

  logic fs_a, fs_b, fe_a, fe_b, fs_sel, fe_sel;
  logic target, tgt_busy, to_hit, guard_ok;
  logic accept_fs, to_fire, sw_exit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign fs_a     = sp_en_chA && (dt_chA == 6'h00);
  assign fs_b     = sp_en_chB && (dt_chB == 6'h00);
  assign fe_a     = sp_en_chA && (dt_chA == 6'h01);
  assign fe_b     = sp_en_chB && (dt_chB == 6'h01);
  assign fs_sel   = mux_sel_q ? fs_b : fs_a;
  assign fe_sel   = mux_sel_q ? fe_b : fe_a;
  assign target   = arb_en ? ~mux_sel_q : fixed_sel;
  assign tgt_busy = target ? (lp_en_chB || d2c_payload_en_chB)
                           : (lp_en_chA || d2c_payload_en_chA);
  assign to_hit   = (to_cnt_q == TO_LAST);
  assign guard_ok = (guard_cnt_q >= GUARD_LAST);

  always_ff @(posedge rx_byte_clk_fr or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= WAIT_FS;
      to_cnt_q       <= '0;
      guard_cnt_q    <= '0;
      mux_sel_q      <= 1'b0;
      frame_active_q <= 1'b0;
      timeout_q      <= 1'b0;
      drop_a_q       <= '0;
      drop_b_q       <= '0;
    end else begin
      state_q        <= state_d;
      to_cnt_q       <= to_cnt_d;
      guard_cnt_q    <= guard_cnt_d;
      mux_sel_q      <= mux_sel_d;
      frame_active_q <= frame_active_d;
      timeout_q      <= timeout_d;
      drop_a_q       <= drop_a_d;
      drop_b_q       <= drop_b_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q + TO_W'(1);
    guard_cnt_d = '0;
    accept_fs   = 1'b0;
    to_fire     = 1'b0;
    sw_exit     = 1'b0;
    case (state_q)
      WAIT_FS: begin
        // A pending fixed-channel change outranks a frame start on the old channel
        if (!arb_en && (fixed_sel != mux_sel_q)) begin
          state_d  = SWITCH;
          to_cnt_d = '0;
        end else if (fs_sel) begin
          state_d   = IN_FRAME;
          to_cnt_d  = '0;
          accept_fs = 1'b1;
        end else if (arb_en && to_hit) begin
          state_d  = SWITCH;
          to_cnt_d = '0;
          to_fire  = 1'b1;
        end
      end
      IN_FRAME: begin
        if (fe_sel || to_hit) begin
          state_d  = (target != mux_sel_q) ? SWITCH : WAIT_FS;
          to_cnt_d = '0;
          to_fire  = !fe_sel;
        end else if (fs_sel) begin
          to_cnt_d = '0;
        end
      end
      SWITCH: begin
        to_cnt_d    = '0;
        guard_cnt_d = sat_inc(guard_cnt_q);
        if (guard_ok && !tgt_busy) begin
          state_d     = WAIT_FS;
          guard_cnt_d = '0;
          sw_exit     = 1'b1;
        end
      end
      default: begin
        state_d  = WAIT_FS;
        to_cnt_d = '0;
      end
    endcase
  end

  // Only the FS accepted in WAIT_FS escapes drop counting; everything else is a drop
  always_comb begin
    mux_sel_d      = sw_exit ? target : mux_sel_q;
    frame_active_d = (state_d == IN_FRAME);
    timeout_d      = to_fire;
    drop_a_d       = (fs_a && !(accept_fs && !mux_sel_q)) ? sat_inc(drop_a_q) : drop_a_q;
    drop_b_d       = (fs_b && !(accept_fs &&  mux_sel_q)) ? sat_inc(drop_b_q) : drop_b_q;
  end

  assign mux_sel       = mux_sel_q;
  assign frame_active  = frame_active_q;
  assign timeout_pulse = timeout_q;
  assign drop_cnt_chA  = drop_a_q;
  assign drop_cnt_chB  = drop_b_q;

endmodule

// File: tb/tb_csi2_frame_arbiter.sv
// Scoreboard bench for csi2_frame_arbiter: stimulus queues expected output changes,
// a monitor compares every observed output change against the queue head.
module tb_csi2_frame_arbiter;
  localparam int TO_W        = 20;
  localparam int TIMEOUT_CYC = 400;
  localparam int GUARD_CYC   = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       arb_en = 1'b1, fixed_sel = 1'b0;
  logic       lp_en_chA = 1'b0, lp_en_chB = 1'b0;
  logic       sp_en_chA = 1'b0, sp_en_chB = 1'b0;
  logic       pl_en_chA = 1'b0, pl_en_chB = 1'b0;
  logic [5:0] dt_chA = 6'h3F, dt_chB = 6'h3F;
  logic       mux_sel, frame_active, timeout_pulse;
  logic [7:0] drop_cnt_chA, drop_cnt_chB;

  csi2_frame_arbiter #(.TO_W(TO_W), .TIMEOUT_CYC(TIMEOUT_CYC), .GUARD_CYC(GUARD_CYC)) dut (
    .rx_byte_clk_fr(clk), .reset_n(reset_n), .arb_en(arb_en), .fixed_sel(fixed_sel),
    .lp_en_chA(lp_en_chA), .lp_en_chB(lp_en_chB), .sp_en_chA(sp_en_chA), .sp_en_chB(sp_en_chB),
    .d2c_payload_en_chA(pl_en_chA), .d2c_payload_en_chB(pl_en_chB),
    .dt_chA(dt_chA), .dt_chB(dt_chB), .mux_sel(mux_sel), .frame_active(frame_active),
    .timeout_pulse(timeout_pulse), .drop_cnt_chA(drop_cnt_chA), .drop_cnt_chB(drop_cnt_chB));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic       mux;
    logic       fa;
    logic       to;
    logic [7:0] da;
    logic [7:0] db;
  } ev_t;

  ev_t        exp_q[$];
  logic       e_mux = 1'b0, e_fa = 1'b0, e_to = 1'b0;
  logic [7:0] e_da = 8'd0, e_db = 8'd0;
  int         vectors = 0, miscompares = 0;

  task automatic push(input int c);
    ev_t e;
    e.c = c; e.mux = e_mux; e.fa = e_fa; e.to = e_to; e.da = e_da; e.db = e_db;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Inputs set after go(e) returns are sampled on posedge number e.
  task automatic go(input int e);
    while (cyc < e - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sp(input logic ch, input logic [5:0] dt, input int e);
    go(e);
    if (ch) begin sp_en_chB = 1'b1; dt_chB = dt; end
    else    begin sp_en_chA = 1'b1; dt_chA = dt; end
    go(e + 1);
    if (ch) begin sp_en_chB = 1'b0; dt_chB = 6'h3F; end
    else    begin sp_en_chA = 1'b0; dt_chA = 6'h3F; end
  endtask

  // Monitor: any change of the output bundle must match the next queued event.
  initial begin : monitor
    logic [18:0] prev, cur, want;
    ev_t e;
    while (cyc < 3) @(negedge clk);
    prev = {mux_sel, frame_active, timeout_pulse, drop_cnt_chA, drop_cnt_chB};
    forever begin
      @(negedge clk);
      cur = {mux_sel, frame_active, timeout_pulse, drop_cnt_chA, drop_cnt_chB};
      if (cur !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change @%0d: got mux/fa/to/dA/dB=%h, expected no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          want = {e.mux, e.fa, e.to, e.da, e.db};
          if (cur !== want || cyc != e.c) begin
            miscompares++;
            $display("FAIL event: got %h @%0d, expected %h @%0d", cur, cyc, want, e.c);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int R, E0, E1, E2, E3, E4;
    ev_t e;
    go(4);
    @(negedge clk);
    check("rst_mux_sel", {7'd0, mux_sel}, 8'd0);
    check("rst_frame_active", {7'd0, frame_active}, 8'd0);
    check("rst_timeout", {7'd0, timeout_pulse}, 8'd0);
    check("rst_drop_a", drop_cnt_chA, 8'd0);
    check("rst_drop_b", drop_cnt_chB, 8'd0);

    // Timeout in WAIT_FS with no FS on A, then switch to B after the guard
    R = 6;
    go(R);
    reset_n = 1'b1;
    e_to = 1'b1; push(R + TIMEOUT_CYC - 1);
    e_to = 1'b0; push(R + TIMEOUT_CYC);
    e_mux = 1'b1; push(R + TIMEOUT_CYC + GUARD_CYC - 1);

    // Full frame on B, round robin back to A
    E0 = R + 420;
    e_fa = 1'b1; push(E0);       sp(1'b1, 6'h00, E0);
    e_fa = 1'b0; push(E0 + 100); sp(1'b1, 6'h01, E0 + 100);
    e_mux = 1'b0; push(E0 + 100 + GUARD_CYC);

    // Frame on A: drops on B, a repeat FS on A, busy target delays the switch
    E1 = E0 + 120;
    e_fa = 1'b1; push(E1); sp(1'b0, 6'h00, E1);
    for (int k = 1; k <= 3; k++) begin
      e_db = 8'(k); push(E1 + 2 * k); sp(1'b1, 6'h00, E1 + 2 * k);
    end
    e_da = 8'd1; push(E1 + 8); sp(1'b0, 6'h00, E1 + 8);
    go(E1 + 15); lp_en_chB = 1'b1;
    e_fa = 1'b0; push(E1 + 20); sp(1'b0, 6'h01, E1 + 20);
    go(E1 + 33); pl_en_chB = 1'b1;
    go(E1 + 35); lp_en_chB = 1'b0;
    go(E1 + 36); lp_en_chA = 1'b1;
    e_mux = 1'b1; push(E1 + 38);
    go(E1 + 38); pl_en_chB = 1'b0;
    go(E1 + 41); lp_en_chA = 1'b0;

    // Short frame on B, back to A
    E2 = E1 + 50;
    e_fa = 1'b1; push(E2);      sp(1'b1, 6'h00, E2);
    e_fa = 1'b0; push(E2 + 10); sp(1'b1, 6'h01, E2 + 10);
    e_mux = 1'b0; push(E2 + 10 + GUARD_CYC);

    // Frame on A with 300 back-to-back FS on B: drop_cnt_chB saturates
    E3 = E2 + 30;
    e_fa = 1'b1; push(E3); sp(1'b0, 6'h00, E3);
    for (int k = 1; k <= 252; k++) begin
      e_db = 8'(3 + k); push(E3 + k);
    end
    go(E3 + 1);   sp_en_chB = 1'b1; dt_chB = 6'h00;
    go(E3 + 301); sp_en_chB = 1'b0; dt_chB = 6'h3F;
    go(E3 + 305); arb_en = 1'b0; fixed_sel = 1'b0;
    e_fa = 1'b0; push(E3 + 310); sp(1'b0, 6'h01, E3 + 310);

    // Fixed mode: long idle without timeout, then fixed_sel=1 moves to B and stays
    E4 = E3 + 800;
    go(E4); fixed_sel = 1'b1;
    e_mux = 1'b1; push(E4 + GUARD_CYC);
    e_fa = 1'b1; push(E4 + 20); sp(1'b1, 6'h00, E4 + 20);
    e_fa = 1'b0; push(E4 + 40); sp(1'b1, 6'h01, E4 + 40);
    e_da = 8'd2; push(E4 + 45); sp(1'b0, 6'h00, E4 + 45);
    e_fa = 1'b1; push(E4 + 50); sp(1'b1, 6'h00, E4 + 50);
    e_fa = 1'b0; push(E4 + 60); sp(1'b1, 6'h01, E4 + 60);
    e_fa = 1'b1; push(E4 + 70); sp(1'b1, 6'h00, E4 + 70);

    // Reset mid-frame on B, then simultaneous FS on both channels
    e_mux = 1'b0; e_fa = 1'b0; e_da = 8'd0; e_db = 8'd0; push(E4 + 79);
    go(E4 + 80); reset_n = 1'b0; arb_en = 1'b1; fixed_sel = 1'b0;
    go(E4 + 85); reset_n = 1'b1;
    e_fa = 1'b1; e_db = 8'd1; push(E4 + 90);
    go(E4 + 90);
    sp_en_chA = 1'b1; dt_chA = 6'h00; sp_en_chB = 1'b1; dt_chB = 6'h00;
    go(E4 + 91);
    sp_en_chA = 1'b0; dt_chA = 6'h3F; sp_en_chB = 1'b0; dt_chB = 6'h3F;
    e_fa = 1'b0; push(E4 + 100); sp(1'b0, 6'h01, E4 + 100);
    e_mux = 1'b1; push(E4 + 100 + GUARD_CYC);

    go(E4 + 130);
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event: got no output change by cycle %0d, expected one @%0d", cyc, e.c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
